// File: rtl/blvds_pkg.sv
// Shared BLVDS link definitions: framing words, transmitter state encoding and
// the payload length type, common to the transmitter and the receiver side.
package blvds_pkg;

   localparam logic [15:0] HEAD_WORD   = 16'hF0C3;
   localparam logic [15:0] EPILOG_WORD = 16'h3C0F;
   localparam logic [15:0] IDLE_WORD   = 16'h0000;
   localparam logic [15:0] FILL_WORD   = 16'hDEAD;
   localparam int          GAP_CYC     = 4;

   typedef logic [7:0] len_t;

   // Each state is named for the word currently on the link.
   typedef enum logic [2:0] {
      S_IDLE,
      S_HEAD,
      S_LEN,
      S_DATA,
      S_EPI,
      S_GAP
   } tx_state_e;

   // An underflowed frame gets an inverted epilog so the far end flags it.
   function automatic logic [15:0] epilogOf(input logic [15:0] sum, input logic ufl);
      return ufl ? ~(EPILOG_WORD ^ sum) : (EPILOG_WORD ^ sum);
   endfunction

endpackage

// File: rtl/blvds_frame_tx_if.sv
// Bundle between the frame transmitter (master) and its FIFO/link/control
// peers (slave); the transmitter's FSM state is exported for observation.
interface blvds_frame_tx_if;
   import blvds_pkg::*;

   // oRD_REQ acknowledges the show-ahead word on iDATA in the same cycle it is
   // high (only when iEMPTY=0); oTX_VALID qualifies oTX_DATA with no backpressure.
   logic        iSTART;
   len_t        iLEN;
   logic [15:0] iDATA;
   logic        iEMPTY;
   logic        oRD_REQ;
   logic [15:0] oTX_DATA;
   logic        oTX_VALID;
   logic        oBUSY;
   logic        oLEN_ERR;
   logic        oUNDERFLOW;
   logic [15:0] oFRAME_CNT;
   tx_state_e   oSTATE;

   modport master (
      input  iSTART, iLEN, iDATA, iEMPTY,
      output oRD_REQ, oTX_DATA, oTX_VALID, oBUSY, oLEN_ERR, oUNDERFLOW,
             oFRAME_CNT, oSTATE
   );

   modport slave (
      output iSTART, iLEN, iDATA, iEMPTY,
      input  oRD_REQ, oTX_DATA, oTX_VALID, oBUSY, oLEN_ERR, oUNDERFLOW,
             oFRAME_CNT, oSTATE
   );

endinterface

// File: rtl/blvds_frame_tx.sv
// BLVDS frame transmitter: header, length, payload, epilog checksum, idle gap.
// FIFO underflow pads with FILL words and corrupts the epilog instead of stalling.
module blvds_frame_tx
   import blvds_pkg::*;
#(
   parameter len_t MAX_LEN = 8'd255
) (
   input logic              iCLK,
   input logic              iRST,
   blvds_frame_tx_if.master bus
);

   localparam int GAP_W = $clog2(GAP_CYC + 1);

   tx_state_e        rState, nextState;
   len_t             rRem, nextRem;
   len_t             rLen, nextLen;
   logic [15:0]      rSum, nextSum;
   logic             rUfl, nextUfl;
   logic [GAP_W-1:0] rGap, nextGap;
   logic [15:0]      rTxData, nextTxData;
   logic             rTxValid, nextTxValid;
   logic             rLenErr, nextLenErr;
   logic             rUnderflow, nextUnderflow;
   logic [15:0]      rFrameCnt, nextFrameCnt;
   logic             rdReq;
   logic [15:0]      fetchWord;

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         rState     <= S_IDLE;
         rRem       <= '0;
         rLen       <= '0;
         rSum       <= '0;
         rUfl       <= 1'b0;
         rGap       <= '0;
         rTxData    <= IDLE_WORD;
         rTxValid   <= 1'b0;
         rLenErr    <= 1'b0;
         rUnderflow <= 1'b0;
         rFrameCnt  <= '0;
      end else begin
         rState     <= nextState;
         rRem       <= nextRem;
         rLen       <= nextLen;
         rSum       <= nextSum;
         rUfl       <= nextUfl;
         rGap       <= nextGap;
         rTxData    <= nextTxData;
         rTxValid   <= nextTxValid;
         rLenErr    <= nextLenErr;
         rUnderflow <= nextUnderflow;
         rFrameCnt  <= nextFrameCnt;
      end
   end

   // Outputs are computed for the state being entered, so the registered word
   // always matches the state name.
   always_comb begin
      nextState     = rState;
      nextRem       = rRem;
      nextLen       = rLen;
      nextSum       = rSum;
      nextUfl       = rUfl;
      nextGap       = rGap;
      nextTxData    = IDLE_WORD;
      nextTxValid   = 1'b0;
      nextLenErr    = 1'b0;
      nextUnderflow = 1'b0;
      nextFrameCnt  = rFrameCnt;
      rdReq         = 1'b0;
      fetchWord     = bus.iEMPTY ? FILL_WORD : bus.iDATA;

      case (rState)
         S_IDLE: begin
            if (bus.iSTART) begin
               if (bus.iLEN != 8'd0 && bus.iLEN <= MAX_LEN) begin
                  nextState   = S_HEAD;
                  nextRem     = bus.iLEN;
                  nextLen     = bus.iLEN;
                  nextSum     = '0;
                  nextUfl     = 1'b0;
                  nextTxData  = HEAD_WORD;
                  nextTxValid = 1'b1;
               end else begin
                  nextLenErr = 1'b1;
               end
            end
         end
         S_HEAD: begin
            nextState   = S_LEN;
            nextTxData  = {8'h00, rLen};
            nextTxValid = 1'b1;
         end
         S_LEN, S_DATA: begin
            if (rRem != 8'd0) begin
               // Fetch slot: an empty FIFO still consumes a slot, padded with FILL.
               nextState     = S_DATA;
               nextRem       = rRem - 8'd1;
               nextTxData    = fetchWord;
               nextTxValid   = 1'b1;
               nextSum       = rSum + fetchWord;
               rdReq         = !bus.iEMPTY;
               nextUnderflow = bus.iEMPTY;
               nextUfl       = rUfl | bus.iEMPTY;
            end else begin
               nextState    = S_EPI;
               nextTxData   = epilogOf(rSum, rUfl);
               nextTxValid  = 1'b1;
               nextFrameCnt = rFrameCnt + 16'd1;
            end
         end
         S_EPI: begin
            nextState = S_GAP;
            nextGap   = GAP_W'(GAP_CYC - 1);
         end
         S_GAP: begin
            if (rGap == '0) begin
               nextState = S_IDLE;
            end else begin
               nextGap = rGap - 1'b1;
            end
         end
         default: begin
            nextState = S_IDLE;
         end
      endcase
   end

   assign bus.oRD_REQ    = rdReq && !iRST;
   assign bus.oTX_DATA   = rTxData;
   assign bus.oTX_VALID  = rTxValid;
   assign bus.oBUSY      = (rState != S_IDLE);
   assign bus.oLEN_ERR   = rLenErr;
   assign bus.oUNDERFLOW = rUnderflow;
   assign bus.oFRAME_CNT = rFrameCnt;
   assign bus.oSTATE     = rState;

endmodule
